apb_master_bridge: RTL
======================

Name: apb_master_bridge

Overview:
Synthesizable APB master that converts a simple valid/ready command stream into APB3 transfers on the register-file bus (PSEL/PENABLE/PWRITE/PADDR/PWDATA). It returns one response per command: read data, slave error and timeout status.
It replaces the behavioural bus driver as the single master upstream of the `top` register block. That block exposes regr_in/regw_out and has AWIDTH=4, DWIDTH=8.
It issues back-to-back transfers when commands are queued.

Parameters:
AWIDTH, 4, APB address width
DWIDTH, 8, APB data width
TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables timeout
TCW, 5, width of wait-state counter; must hold TIMEOUT

Ports:
PCLK  in  1  bus clock, all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready at rising edge
cmd_write  in  1  1=write, 0=read
cmd_addr  in  AWIDTH  target address
cmd_wdata  in  DWIDTH  write data (ignored for reads)
rsp_valid  out  1  one-cycle pulse, response for the oldest accepted command
rsp_rdata  out  DWIDTH  read data (0 for writes, errors and timeouts)
rsp_err  out  1  PSLVERR sampled at completion, or timeout
rsp_timeout  out  1  transfer aborted by timeout
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  AWIDTH  APB address
PWDATA  out  DWIDTH  APB write data
PRDATA  in  DWIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB slave error

Behaviour:
- Reset (PRESETn low, asynchronous):
  - state=IDLE; wait counter=0.
  - All outputs 0 except cmd_ready, which is 1 as IDLE dictates.
  - Deassertion is sampled on the next PCLK edge.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - PSEL=0, PENABLE=0.
  - cmd_ready=1.
  - On cmd_valid: latch write/addr/wdata into PWRITE/PADDR/PWDATA and go to SETUP.
- SETUP (exactly 1 cycle):
  - PSEL=1, PENABLE=0, cmd_ready=0.
  - Go to ACCESS; clear wait counter.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PADDR/PWRITE/PWDATA stay stable for the whole transfer.
- Completion: PREADY=1 sampled in ACCESS.
  - Next cycle: rsp_valid=1 and rsp_err=PSLVERR.
  - rsp_rdata = PRDATA for a read with PSLVERR=0; otherwise 0.
  - rsp_timeout=0.
- Back-to-back:
  - cmd_ready = (state==IDLE) | (state==ACCESS & PREADY & !timeout_hit). This is combinational from PREADY.
  - If a command is accepted on the completion edge, the next state is SETUP (PSEL stays 1, PENABLE drops to 0) and the APB fields load the new command.
  - Otherwise the next state is IDLE.
- Latency:
  - Zero-wait transfer: accept edge N, SETUP N+1, ACCESS N+2, rsp_valid during N+3.
  - Throughput is one transfer per 2 cycles when streaming.
- Wait states:
  - Each ACCESS cycle with PREADY=0 increments the wait counter.
  - With TIMEOUT>0, when the counter equals TIMEOUT and PREADY=0: abort. Next state IDLE, PSEL=PENABLE=0.
  - Abort response: rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - The aborted cycle does not accept a command.
  - TIMEOUT=0: wait indefinitely; counter saturates and does not wrap.
- rsp_valid:
  - Exactly one pulse per accepted command; there is no backpressure, so the consumer must take it.
  - rsp_* fields hold their value until the next response.
  - rsp_err/rsp_timeout are only meaningful while rsp_valid=1.
- PSLVERR is sampled only on the completion cycle and ignored otherwise.
- Reset mid-transfer: bus returns to idle immediately and no response is generated. The in-flight command is lost, and its source must reissue.
- cmd fields are sampled only at acceptance; changes while cmd_ready=0 have no effect.

Test Plan:
- Write 0xA5 to addr 2, slave PREADY=1 immediately -> PSEL rises edge+1, PENABLE edge+2; PADDR=2, PWDATA=0xA5, PWRITE=1 stable through ACCESS; rsp_valid edge+3 with err=0; regw_out_2 reads 0xA5.
- Read addr 5 with regr_in_0=0x3C mapped there, slave inserts 2 wait states -> ACCESS lasts 3 cycles; rsp_rdata=0x3C, rsp_err=0; cmd_ready=0 throughout.
- Read of unmapped addr 0xF, slave PSLVERR=1 on completion -> rsp_valid with rsp_err=1, rsp_timeout=0, rsp_rdata=0x00.
- Streaming: cmd_valid held with writes 0x11@0, 0x22@1, 0x33@2 -> PSEL stays 1 across all three, PENABLE toggles 0/1; three rsp_valid pulses 2 cycles apart; regw_out_0..2 = 0x11, 0x22, 0x33.
- TIMEOUT=16, PREADY held 0 -> abort after 16 wait cycles; PSEL=0 next cycle; rsp_err=1, rsp_timeout=1; next command then completes normally.
- PRESETn pulsed low during ACCESS of a write -> PSEL/PENABLE/rsp_valid go 0 asynchronously and no response is issued; cmd_ready=1 after release; a new read completes correctly.

Source files
------------

// File: rtl/apb_master_bridge.sv
// APB3 master that turns a valid/ready command stream into bus transfers and
// returns exactly one response per accepted command.
module apb_master_bridge #(
  parameter int AWIDTH  = 4,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 16,
  parameter int TCW     = 5
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [TCW-1:0] WAIT_ZERO = {TCW{1'b0}};
  localparam logic [TCW-1:0] WAIT_ONE  = {{(TCW-1){1'b0}}, 1'b1};
  localparam logic [TCW-1:0] WAIT_MAX  = {TCW{1'b1}};
  localparam logic [TCW-1:0] TIMEOUT_C = TCW'(TIMEOUT);
  localparam bit             TO_EN     = (TIMEOUT != 0);

  state_t              state_q, state_d;
  logic [TCW-1:0]      wait_q, wait_d;
  logic                pwrite_q, pwrite_d;
  logic [AWIDTH-1:0]   paddr_q, paddr_d;
  logic [DWIDTH-1:0]   pwdata_q, pwdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic                timeout_hit_s;
  logic                cmd_ready_s;
  logic                accept_s;

  // Handshake decode: a new command may ride on the completion edge of the current one.
  always_comb begin
    timeout_hit_s = TO_EN && (state_q == ACCESS) && !PREADY && (wait_q == TIMEOUT_C);
    cmd_ready_s   = (state_q == IDLE) || ((state_q == ACCESS) && PREADY && !timeout_hit_s);
    accept_s      = cmd_valid && cmd_ready_s;
  end

  // Next-state, wait counter, APB field and response computation.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    if (accept_s) begin
      pwrite_d = cmd_write;
      paddr_d  = cmd_addr;
      pwdata_d = cmd_wdata;
    end else begin
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
    end

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        wait_d  = WAIT_ZERO;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (!pwrite_q && !PSLVERR) ? PRDATA : {DWIDTH{1'b0}};
          state_d       = accept_s ? SETUP : IDLE;
        end else if (timeout_hit_s) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = {DWIDTH{1'b0}};
          state_d       = IDLE;
        end else begin
          // Saturate so an unbounded wait (timeout disabled) never wraps.
          wait_d  = (wait_q != WAIT_MAX) ? (wait_q + WAIT_ONE) : wait_q;
          state_d = ACCESS;
        end
      end
      default: begin
        state_d = IDLE;
        wait_d  = WAIT_ZERO;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight transfer silently.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      wait_q        <= WAIT_ZERO;
      pwrite_q      <= 1'b0;
      paddr_q       <= {AWIDTH{1'b0}};
      pwdata_q      <= {DWIDTH{1'b0}};
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= {DWIDTH{1'b0}};
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_s;
  assign PSEL        = (state_q != IDLE);
  assign PENABLE     = (state_q == ACCESS);
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
